dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_responder_if.sv | 19 +
 rtl/dmem_timer.sv | 70 +++++++
 rtl/dmem_responder.sv | 85 ++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and decode helper for the data-memory responder.
// Holds the RAM/MMIO bases, the timer register offsets, the STATUS/CTRL bit
// positions and the register-select type used by the top and the timer.
package dmem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   // RAM is every address whose top nibble matches this region.
   localparam logic [3:0]        RAM_REGION = 4'h0;
   localparam logic [ADDR_W-1:0] MMIO_BASE  = 32'hFFFF_0000;

   localparam logic [3:0] OFF_COUNT  = 4'h0;
   localparam logic [3:0] OFF_CMP    = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;
   localparam logic [3:0] OFF_CTRL   = 4'hC;

   localparam int unsigned STATUS_MATCH_BIT = 0;
   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_IRQEN_BIT   = 1;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_COUNT,
      REG_CMP,
      REG_STATUS,
      REG_CTRL
   } regSel_t;

   // Exact-match decode of the timer register window; anything else is REG_NONE.
   function automatic regSel_t decodeReg(input logic [ADDR_W-1:0] addr);
      decodeReg = REG_NONE;
      if (addr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]) begin
         case (addr[3:0])
            OFF_COUNT:  decodeReg = REG_COUNT;
            OFF_CMP:    decodeReg = REG_CMP;
            OFF_STATUS: decodeReg = REG_STATUS;
            OFF_CTRL:   decodeReg = REG_CTRL;
            default:    decodeReg = REG_NONE;
         endcase
      end
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU memory-stage bus between the core (master) and the data-memory
// responder (slave).
//   memwrite : write strobe          addr  : byte address
//   wdata    : store data            rdata : load data (combinational)
//   irq      : timer interrupt level err   : one-cycle rejected-write pulse
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              memwrite;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              irq;
   logic              err;

   modport master (output memwrite, addr, wdata, input rdata, irq, err);
   modport slave  (input memwrite, addr, wdata, output rdata, irq, err);

endinterface

// File: rtl/dmem_timer.sv
// Memory-mapped free-running timer with compare-match interrupt.
// Only built when DMEM_TIMER_EN is defined.
//   clk, rst : clock and synchronous active-high reset
//   wrEn     : qualified register write (aligned, mapped, writable)
//   sel      : decoded register for both read and write
//   wdata    : store data
//   rdValue  : read-back of the selected register (unused bits zero)
//   irq      : MATCH & IRQEN
module dmem_timer
   import dmem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn,
   input  regSel_t           sel,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdValue,
   output logic              irq
);

   logic [DATA_W-1:0] count;
   logic [DATA_W-1:0] countNext;
   logic [DATA_W-1:0] cmp;
   logic              match;
   logic              en;
   logic              irqEn;

   // Kept as a separate net so a bench can preload the counter near wrap.
   assign countNext = count + DATA_W'(1);

   // Timer state; compare uses the pre-increment count and the current CMP,
   // so a CMP write only affects the comparison from the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         cmp   <= '1;
         match <= 1'b0;
         en    <= 1'b0;
         irqEn <= 1'b0;
      end else begin
         if (en) count <= countNext;
         if (wrEn && sel == REG_CMP) cmp <= wdata;
         if (wrEn && sel == REG_CTRL) begin
            en    <= wdata[CTRL_EN_BIT];
            irqEn <= wdata[CTRL_IRQEN_BIT];
         end
         // Set has priority over a same-cycle write-1-to-clear.
         if (en && count == cmp) match <= 1'b1;
         else if (wrEn && sel == REG_STATUS && wdata[STATUS_MATCH_BIT]) match <= 1'b0;
      end
   end

   // Register read-back.
   always_comb begin
      rdValue = '0;
      case (sel)
         REG_COUNT:  rdValue = count;
         REG_CMP:    rdValue = cmp;
         REG_STATUS: rdValue[STATUS_MATCH_BIT] = match;
         REG_CTRL: begin
            rdValue[CTRL_EN_BIT]    = en;
            rdValue[CTRL_IRQEN_BIT] = irqEn;
         end
         default:    rdValue = '0;
      endcase
   end

   assign irq = match & irqEn;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU memory stage: word RAM with zero-latency
// read, optional MMIO timer, and a registered error pulse on rejected writes.
// Optional feature macro: DMEM_TIMER_EN (undefined -> timer window unmapped,
// irq tied low, no timer flops).
//   clk : clock            rst : synchronous active-high reset
//   bus : dmem_responder_if.slave (memwrite/addr/wdata in, rdata/irq/err out)
// Parameter DEPTH: number of 32-bit RAM words, power of two, 16..4096.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input logic              clk,
   input logic              rst,
   dmem_responder_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

`ifdef DMEM_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
`else
   localparam bit TIMER_EN = 1'b0;
`endif

   logic              isRam;
   logic              aligned;
   logic              writeOk;
   logic              ramWe;
   logic              errQ;
   regSel_t           regSel;
   logic [IDX_W-1:0]  ramIdx;
   logic [DATA_W-1:0] timerRd;
   logic [DATA_W-1:0] mem [DEPTH];

   // Address decode; high RAM index bits are dropped, so RAM aliases.
   always_comb begin
      isRam   = bus.addr[31:28] == RAM_REGION;
      aligned = bus.addr[1:0] == 2'b00;
      regSel  = TIMER_EN ? decodeReg(bus.addr) : REG_NONE;
      ramIdx  = bus.addr[IDX_W+1:2];
      writeOk = aligned && (isRam || regSel inside {REG_CMP, REG_STATUS, REG_CTRL});
      ramWe   = bus.memwrite && isRam && aligned && !rst;
   end

   // One-cycle pulse for any write that was dropped.
   always_ff @(posedge clk) begin
      if (rst) errQ <= 1'b0;
      else     errQ <= bus.memwrite && !writeOk;
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (ramWe) mem[ramIdx] <= bus.wdata;
   end

   // Zero-latency read mux.
   always_comb begin
      if (isRam)                  bus.rdata = mem[ramIdx];
      else if (regSel != REG_NONE) bus.rdata = timerRd;
      else                        bus.rdata = '0;
   end

   assign bus.err = errQ;

`ifdef DMEM_TIMER_EN
   logic timerIrq;

   dmem_timer uTimer (
      .clk     (clk),
      .rst     (rst),
      .wrEn    (bus.memwrite && writeOk && !isRam),
      .sel     (regSel),
      .wdata   (bus.wdata),
      .rdValue (timerRd),
      .irq     (timerIrq)
   );

   assign bus.irq = timerIrq;
`else
   assign timerRd = '0;
   assign bus.irq = 1'b0;
`endif

endmodule
